y86_encode_instruction: RTL and testbench
=========================================

// Module: y86_encode_instruction
// PURPOSE
// Inverse of the fetch-stage instruction splitter. Accepts one decoded Y86 instruction per
// handshake, packs it into the byte layout fetch expects, and writes it byte-serially into
// instruction memory at an auto-incrementing address. Used by the program loader and self-test
// to build code images in memory.
// PARAMETERS
// ADDR_W  32  width of the instruction-memory byte address; the write pointer wraps mod 2**ADDR_W
// PORTS
// clock       in   1       single clock; all state updates on rising edge
// reset_n     in   1       synchronous, active-low reset
// addr_load   in   1       load start_addr into write pointer (honoured in IDLE only)
// start_addr  in   ADDR_W  new write-pointer value
// in_valid    in   1       instruction fields valid
// in_ready    out  1       encoder can accept an instruction (high only in IDLE)
// icode/ifun  in   4/4     opcode and function nibbles
// rA/rB       in   4/4     register IDs (forced to F where the format has no field)
// valC        in   32      constant word
// mem_we      out  1       byte write request
// mem_ready   in   1       memory accepts the byte this cycle
// mem_addr    out  ADDR_W  byte address of the current write
// mem_wdata   out  8       byte being written
// instr_len   out  3       length of instruction held (1, 2, 5 or 6)
// done        out  1       one-cycle pulse after last byte of an instruction is accepted
// bad_icode   out  1       one-cycle pulse: icode C..F was offered; nothing written
// next_addr   out  ADDR_W  current write-pointer value
// BEHAVIOUR
// - Reset: state IDLE, pointer 0, byte index 0, mem_we=0, mem_addr=0, mem_wdata=0,
//   instr_len=0, done=0, bad_icode=0, in_ready=0 during reset cycle, 1 in IDLE after.
// - Length: icode 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 5; 3,4,5 -> 6.
// - Byte 0 = {icode,ifun}. Regid byte = {rB[3:0] high nibble, rA[3:0] low nibble}.
//   icode 3: rA forced F; icode A,B: rB forced F, regardless of inputs.
// - valC little-endian: icode 3,4,5 -> bytes 2..5; icode 7,8 -> bytes 1..4.
// - Accept: in_valid & in_ready captures packed 48-bit image and length; state -> EMIT next cycle.
//   Invalid icode (C..F): not captured, bad_icode pulses next cycle, stay IDLE, pointer unchanged.
// - EMIT: mem_we=1, mem_addr=pointer, mem_wdata=byte[index]. On mem_we & mem_ready: pointer+1
//   (wraps), index+1. Outputs held stable while mem_ready=0. After last byte accepted: index=0,
//   done pulses on the following cycle, state -> IDLE. One idle bubble between instructions.
// - addr_load in IDLE: pointer <= start_addr. Same cycle as an accepted in_valid: load applies
//   first, instruction writes from start_addr. addr_load during EMIT ignored.
// - reset_n low mid-EMIT: aborts immediately, partial instruction stays in memory, all regs reset.
// - mem_addr/mem_wdata are 0 whenever mem_we=0.
// STRUCTURE
// - Shared package y86_pkg: icode constants (HALT..POPL), INSTR_MAX_BYTES=6, state enum
//   {IDLE, EMIT}, pure function y86_instr_len(icode) returning 3-bit length (0 for invalid).
// - One sub-module: y86_pack_instruction (combinational) -> 48-bit image + length + valid flag;
//   top holds FSM, pointer, index and byte mux.
// TESTING
// - halt (icode0) at addr 0x100 -> one write 0x00 @0x100; done; next_addr=0x101.
// - irmovl icode3 rA=0 rB=3 valC=0x12345678 @0x200 -> 30 3F 78 56 34 12 @0x200..0x205 (rA forced F).
// - call icode8 valC=0x00000040 -> 80 40 00 00 00, five writes, no regid byte.
// - pushl icode A rA=0 rB=5 with mem_ready low 3 cycles on byte 1 -> A0 held, then F0; data/addr stable.
// - icode 0xC offered -> bad_icode pulse, zero writes, in_ready stays 1, next_addr unchanged.
// - ADDR_W=32, start 0xFFFFFFFE, rrmovl icode2 rA=1 rB=2 -> 20 @..FE, 21 @..FF, next_addr=0;
//   reset_n low after first byte of a 6-byte op -> mem_we=0, next_addr=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 opcode constants, FSM state type and instruction-length helper.
// Latency: none (package only).
// Backpressure: not applicable.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVL = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  localparam int INSTR_MAX_BYTES = 6;

  typedef enum logic {IDLE, EMIT} state_t;

  // Encoded length in bytes; 0 marks an icode with no defined format.
  function automatic logic [2:0] y86_instr_len(input logic [3:0] icode);
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                 y86_instr_len = 3'd1;
      ICODE_RRMOVL, ICODE_OPL, ICODE_PUSHL, ICODE_POPL: y86_instr_len = 3'd2;
      ICODE_JXX, ICODE_CALL:                            y86_instr_len = 3'd5;
      ICODE_IRMOVL, ICODE_RMMOVL, ICODE_MRMOVL:         y86_instr_len = 3'd6;
      default:                                          y86_instr_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_pack_instruction.sv
// Packs decoded Y86 fields into the little-endian byte image fetch expects (byte 0 in [7:0]).
// Latency: purely combinational.
// Backpressure: none; caller decides when to capture the image.
module y86_pack_instruction
  import y86_pkg::*;
(
  input  logic [3:0]                   icode,
  input  logic [3:0]                   ifun,
  input  logic [3:0]                   ra,
  input  logic [3:0]                   rb,
  input  logic [31:0]                  valc,
  output logic [8*INSTR_MAX_BYTES-1:0] image,
  output logic [2:0]                   len,
  output logic                         valid
);

  logic [3:0] ra_f;
  logic [3:0] rb_f;

  // Build the byte image; register fields absent from the format are forced to F.
  always_comb begin
    image = '0;
    len   = y86_instr_len(icode);
    valid = (len != 3'd0);
    ra_f  = (icode == ICODE_IRMOVL) ? 4'hF : ra;
    rb_f  = (icode == ICODE_PUSHL || icode == ICODE_POPL) ? 4'hF : rb;
    image[7:0] = {icode, ifun};
    case (icode)
      ICODE_RRMOVL, ICODE_OPL, ICODE_PUSHL, ICODE_POPL: begin
        image[15:8] = {rb_f, ra_f};
      end
      ICODE_IRMOVL, ICODE_RMMOVL, ICODE_MRMOVL: begin
        image[15:8]  = {rb_f, ra_f};
        image[47:16] = valc;
      end
      ICODE_JXX, ICODE_CALL: begin
        image[39:8] = valc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/y86_encode_instruction.sv
// Writes one packed Y86 instruction byte-serially into instruction memory at an auto-incrementing pointer.
// Latency: first byte presented the cycle after accept; done pulses the cycle after the last byte is taken.
// Backpressure: in_ready only in IDLE; each byte (addr/data) is held stable until mem_ready.
module y86_encode_instruction
  import y86_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic [31:0]       valc,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [2:0]        instr_len,
  output logic              done,
  output logic              bad_icode,
  output logic [ADDR_W-1:0] next_addr
);

  state_t                       state;
  state_t                       state_nxt;
  logic [ADDR_W-1:0]            ptr;
  logic [2:0]                   idx;
  logic [8*INSTR_MAX_BYTES-1:0] image_q;
  logic [2:0]                   len_q;
  logic [8*INSTR_MAX_BYTES-1:0] pk_image;
  logic [2:0]                   pk_len;
  logic                         pk_valid;
  logic                         accept;
  logic                         byte_ok;
  logic                         last_byte;
  logic [7:0]                   cur_byte;

  y86_pack_instruction u_pack (
    .icode (icode),
    .ifun  (ifun),
    .ra    (ra),
    .rb    (rb),
    .valc  (valc),
    .image (pk_image),
    .len   (pk_len),
    .valid (pk_valid)
  );

  // Handshakes; gating with reset_n makes a mid-instruction reset stop writes the same cycle.
  always_comb begin
    in_ready  = reset_n && (state == IDLE);
    mem_we    = reset_n && (state == EMIT);
    accept    = in_valid && in_ready;
    byte_ok   = mem_we && mem_ready;
    last_byte = byte_ok && (idx == len_q - 3'd1);
  end

  // Select the byte at the current index; outputs read zero when not writing.
  always_comb begin
    case (idx)
      3'd0:    cur_byte = image_q[7:0];
      3'd1:    cur_byte = image_q[15:8];
      3'd2:    cur_byte = image_q[23:16];
      3'd3:    cur_byte = image_q[31:24];
      3'd4:    cur_byte = image_q[39:32];
      3'd5:    cur_byte = image_q[47:40];
      default: cur_byte = 8'h00;
    endcase
    mem_addr  = mem_we ? ptr : '0;
    mem_wdata = mem_we ? cur_byte : 8'h00;
    instr_len = len_q;
    next_addr = ptr;
  end

  // Next-state: leave IDLE only for a valid accepted instruction, return after the last byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && pk_valid) state_nxt = EMIT;
      EMIT:    if (last_byte)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Datapath: pointer load/advance, image capture, byte index and status pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr       <= '0;
      idx       <= 3'd0;
      image_q   <= '0;
      len_q     <= 3'd0;
      done      <= 1'b0;
      bad_icode <= 1'b0;
    end else begin
      done      <= last_byte;
      bad_icode <= accept && !pk_valid;
      if (state == IDLE) begin
        if (addr_load) ptr <= start_addr;
        if (accept && pk_valid) begin
          image_q <= pk_image;
          len_q   <= pk_len;
          idx     <= 3'd0;
        end
      end
      if (byte_ok) begin
        ptr <= ptr + ADDR_W'(1);
        idx <= last_byte ? 3'd0 : idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_y86_encode_instruction.sv
// Randomized bench for y86_encode_instruction with a byte-list reference model and a scoreboard on memory writes.
// Latency: checks one byte per accepted write and done on the cycle after the last byte.
// Backpressure: the bench acts as memory and randomly stalls mem_ready.
module tb_y86_encode_instruction;

  logic        clock;
  logic        reset_n;
  logic        addr_load;
  logic [31:0] start_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [31:0] valc;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [2:0]  instr_len;
  logic        done;
  logic        bad_icode;
  logic [31:0] next_addr;

  int checks;
  int failures;
  logic [31:0] model_ptr;

  y86_encode_instruction #(.ADDR_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .addr_load  (addr_load),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .ra         (ra),
    .rb         (rb),
    .valc       (valc),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .instr_len  (instr_len),
    .done       (done),
    .bad_icode  (bad_icode),
    .next_addr  (next_addr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the byte sequence an instruction occupies in memory, from the Y86 format rules.
  task automatic model_bytes(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                             input logic [3:0] b, input logic [31:0] c,
                             output logic [7:0] eb [6], output int n);
    bit has_reg;
    bit has_const;
    int k;
    for (int j = 0; j < 6; j++) eb[j] = 8'h00;
    has_reg   = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    has_const = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
    if (ic > 4'hB) begin
      n = 0;
      return;
    end
    n = 1;
    eb[0] = {ic, fn};
    if (has_reg) begin
      eb[1] = {(ic == 4'hA || ic == 4'hB) ? 4'hF : b, (ic == 4'h3) ? 4'hF : a};
      n = 2;
    end
    if (has_const) begin
      for (k = 0; k < 4; k++) eb[n + k] = 8'((c >> (8 * k)) & 32'hFF);
      n = n + 4;
    end
  endtask

  // Offer one instruction from IDLE (at a negedge) and follow it to completion.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                           input logic [3:0] b, input logic [31:0] c, input bit load,
                           input logic [31:0] sa, input int stall_at, input int stall_cnt,
                           input bit rnd);
    logic [7:0]  eb [6];
    int          n;
    int          i;
    int          stalls;
    int          guard;
    logic [31:0] base;
    logic [31:0] ea;
    logic        r;
    model_bytes(ic, fn, a, b, c, eb, n);
    chk("in_ready_idle", in_ready, 1);
    icode = ic; ifun = fn; ra = a; rb = b; valc = c;
    in_valid = 1'b1; addr_load = load; start_addr = sa;
    base = load ? sa : model_ptr;
    @(negedge clock);
    in_valid = 1'b0; addr_load = 1'b0;
    model_ptr = base;
    if (n == 0) begin
      chk("bad_icode_pulse", bad_icode, 1);
      chk("bad_no_write", mem_we, 0);
      chk("bad_in_ready", in_ready, 1);
      chk("bad_next_addr", next_addr, base);
      @(negedge clock);
      chk("bad_icode_drop", bad_icode, 0);
      chk("bad_still_idle", mem_we, 0);
      return;
    end
    chk("instr_len", instr_len, n);
    i = 0; stalls = 0; guard = 0;
    while (i < n && guard < 200) begin
      ea = base + 32'(i);
      chk("mem_we", mem_we, 1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, eb[i]);
      chk("no_early_done", done, 0);
      if (i == stall_at && stalls < stall_cnt) r = 1'b0;
      else if (rnd && stalls < 3 && $urandom_range(0, 3) == 0) r = 1'b0;
      else r = 1'b1;
      stalls = r ? 0 : stalls + 1;
      mem_ready = r;
      @(negedge clock);
      guard++;
      if (r) i++;
    end
    if (guard >= 200) chk("write_timeout", 0, 1);
    mem_ready = 1'b0;
    ea = base + 32'(n);
    chk("done_pulse", done, 1);
    chk("done_we_low", mem_we, 0);
    chk("idle_addr_zero", mem_addr, 0);
    chk("idle_data_zero", mem_wdata, 0);
    chk("done_in_ready", in_ready, 1);
    chk("next_addr", next_addr, ea);
    model_ptr = ea;
  endtask

  initial begin
    checks = 0; failures = 0; model_ptr = 32'h0;
    reset_n = 1'b0; addr_load = 1'b0; start_addr = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; ra = '0; rb = '0; valc = '0; mem_ready = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_len", instr_len, 0);
    chk("rst_done", done, 0);
    chk("rst_bad", bad_icode, 0);
    chk("rst_next_addr", next_addr, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", in_ready, 1);

    // halt at 0x100
    run_instr(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 32'h100, -1, 0, 1'b0);
    // irmovl at 0x200, rA forced to F
    run_instr(4'h3, 4'h0, 4'h0, 4'h3, 32'h12345678, 1'b1, 32'h200, -1, 0, 1'b0);
    // call, no regid byte
    run_instr(4'h8, 4'h0, 4'h0, 4'h0, 32'h00000040, 1'b0, 32'h0, -1, 0, 1'b0);
    // pushl with first byte stalled three cycles
    run_instr(4'hA, 4'h0, 4'h0, 4'h5, 32'h0, 1'b0, 32'h0, 0, 3, 1'b0);
    // invalid icode: pointer must not move
    run_instr(4'hC, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, -1, 0, 1'b0);
    // rrmovl across the address wrap
    run_instr(4'h2, 4'h0, 4'h1, 4'h2, 32'h0, 1'b1, 32'hFFFFFFFE, -1, 0, 1'b0);
    chk("wrap_to_zero", next_addr, 0);

    // addr_load while emitting must be ignored
    icode = 4'h5; ifun = 4'h0; ra = 4'h1; rb = 4'h2; valc = 32'hCAFEF00D;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    addr_load = 1'b1; start_addr = 32'h5555;
    mem_ready = 1'b1;
    @(negedge clock);
    addr_load = 1'b0; mem_ready = 1'b0;
    chk("emit_load_ignored", next_addr, model_ptr + 32'd1);
    chk("byte1_after_load", mem_wdata, 8'h21);
    // reset mid-instruction aborts at once
    reset_n = 1'b0;
    #1;
    chk("abort_we_low", mem_we, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("abort_next_addr", next_addr, 0);
    chk("abort_len", instr_len, 0);
    chk("abort_idle_we", mem_we, 0);
    chk("abort_in_ready_back", in_ready, 1);
    model_ptr = 32'h0;
    @(negedge clock);

    // random instructions with random stalls and occasional pointer loads near the wrap
    for (int t = 0; t < 150; t++) begin
      logic [31:0] sa;
      bit          ld;
      ld = ($urandom_range(0, 7) == 0);
      sa = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFA + 32'($urandom_range(0, 5)) : $urandom;
      run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom, ld, sa, -1, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
